// File: rtl/spiflash_resp_pkg.sv
// spiflash_resp_pkg: states and command constants; SPIFLASH_RESP_QUAD_EN adds the MODE/DUMMY states
package spiflash_resp_pkg;
  localparam int ADDR_W = 24;
  localparam logic [7:0] CMD_READ = 8'h03;
  localparam logic [7:0] CMD_QREAD = 8'hEB;
  localparam logic [7:0] CMD_RESET_CRM = 8'hFF;
  localparam logic [1:0] CRM_MODE_BITS = 2'b10;
  typedef enum logic [2:0] {
    IDLE,
    CMD,
    ADDR,
`ifdef SPIFLASH_RESP_QUAD_EN
    MODE,
    DUMMY,
`endif
    DATA,
    IGNORE
  } state_e;
endpackage

// File: rtl/spi_pin_sync.sv
// spi_pin_sync: synchronizes csb/sclk/io into clk and flags sclk rise/fall
module spi_pin_sync #(
  parameter int SYNC_STAGES = 2
) (
  input  logic       clk,
  input  logic       resetn,
  input  logic       csb,
  input  logic       sclk,
  input  logic [3:0] io,
  output logic       csb_s,
  output logic [3:0] io_s,
  output logic       rise,
  output logic       fall
);
  logic [5:0] stg_q [SYNC_STAGES];
  logic [5:0] stg_d [SYNC_STAGES];
  logic       sclk_s, sclk_prev_q;
  // shift chain: new pin values enter stage 0
  always_comb begin
    stg_d[0] = {csb, sclk, io};
    for (int i = 1; i < SYNC_STAGES; i++) stg_d[i] = stg_q[i-1];
  end
  // synchronizer flops; csb resets deasserted (high)
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      for (int i = 0; i < SYNC_STAGES; i++) stg_q[i] <= 6'b100000;
      sclk_prev_q <= 1'b0;
    end else begin
      stg_q <= stg_d;
      sclk_prev_q <= sclk_s;
    end
  end
  assign {csb_s, sclk_s, io_s} = stg_q[SYNC_STAGES-1];
  assign rise = sclk_s & ~sclk_prev_q;
  assign fall = ~sclk_s & sclk_prev_q;
endmodule

// File: rtl/spiflash_responder.sv
// spiflash_responder: SPI NOR read responder backed by a byte store (quad read with SPIFLASH_RESP_QUAD_EN)
module spiflash_responder
  import spiflash_resp_pkg::*;
#(
  parameter int DUMMY_CYCLES = 4,
  parameter int SYNC_STAGES  = 2
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic              flash_csb,
  input  logic              flash_clk,
  input  logic              flash_io0_di,
  input  logic              flash_io1_di,
  input  logic              flash_io2_di,
  input  logic              flash_io3_di,
  output logic              flash_io0_do,
  output logic              flash_io1_do,
  output logic              flash_io2_do,
  output logic              flash_io3_do,
  output logic              flash_io0_oe,
  output logic              flash_io1_oe,
  output logic              flash_io2_oe,
  output logic              flash_io3_oe,
  output logic              mem_valid,
  input  logic              mem_ready,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic [7:0]        mem_rdata,
  output logic              busy,
  output logic              err
);
`ifdef SPIFLASH_RESP_QUAD_EN
  localparam logic QUAD_EN = 1'b1;
`else
  localparam logic QUAD_EN = 1'b0;
`endif
  localparam int CW = (DUMMY_CYCLES > 24) ? $clog2(DUMMY_CYCLES) : 5;
  logic              csb_s, rise, fall, hit;
  logic [3:0]        io_s;
  logic [7:0]        dat;
  state_e            st_q, st_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic [23:0]       sh_q, sh_d;
  logic [ADDR_W-1:0] rd_addr_q, rd_addr_d, mem_addr_q, mem_addr_d;
  logic [7:0]        buf_q, buf_d;
  logic              buf_v_q, buf_v_d, mem_valid_q, mem_valid_d;
  logic [3:0]        do_q, do_d, oe_q, oe_d;
  logic              quad_q, quad_d, crm_q, crm_d, err_q, err_d, busy_q, busy_d;
  spi_pin_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync (
    .clk   (clk),
    .resetn(resetn),
    .csb   (flash_csb),
    .sclk  (flash_clk),
    .io    ({flash_io3_di, flash_io2_di, flash_io1_di, flash_io0_di}),
    .csb_s (csb_s),
    .io_s  (io_s),
    .rise  (rise),
    .fall  (fall)
  );
  // protocol FSM, fetch buffer and output shifter; a fetch only lands if it matches the byte awaited next
  always_comb begin
    st_d = st_q;
    cnt_d = cnt_q;
    sh_d = sh_q;
    rd_addr_d = rd_addr_q;
    buf_d = buf_q;
    buf_v_d = buf_v_q;
    mem_valid_d = mem_valid_q;
    mem_addr_d = mem_addr_q;
    do_d = do_q;
    oe_d = oe_q;
    quad_d = quad_q;
    crm_d = crm_q;
    err_d = err_q;
    busy_d = ~csb_s;
    hit = mem_valid_q & mem_ready & (mem_addr_q == rd_addr_q);
    dat = (cnt_q == '0) ? (buf_v_q ? buf_q : hit ? mem_rdata : 8'hFF) : sh_q[7:0];
    if (mem_valid_q && mem_ready) begin
      mem_valid_d = 1'b0;
      buf_d = hit ? mem_rdata : buf_q;
      buf_v_d = buf_v_q | hit;
    end
    case (st_q)
      IDLE: if (!csb_s) begin
        st_d = crm_q ? ADDR : CMD;
        quad_d = crm_q;
      end
      CMD: if (rise) begin
        sh_d = {sh_q[22:0], io_s[0]};
        cnt_d = cnt_q + CW'(1);
        if (cnt_q == CW'(7)) begin
          cnt_d = '0;
          quad_d = QUAD_EN && sh_d[7:0] == CMD_QREAD;
          st_d = (sh_d[7:0] == CMD_READ || quad_d) ? ADDR : IGNORE;
          crm_d = crm_q && sh_d[7:0] != CMD_RESET_CRM;
          err_d = err_q || (st_d == IGNORE && sh_d[7:0] != CMD_RESET_CRM);
        end
      end
      ADDR: if (rise) begin
        sh_d = quad_q ? {sh_q[19:0], io_s} : {sh_q[22:0], io_s[0]};
        cnt_d = cnt_q + CW'(1);
        if (cnt_q == (quad_q ? CW'(5) : CW'(23))) begin
          cnt_d = '0;
          rd_addr_d = sh_d;
          mem_addr_d = sh_d;
          mem_valid_d = 1'b1;
          buf_v_d = 1'b0;
`ifdef SPIFLASH_RESP_QUAD_EN
          st_d = quad_q ? MODE : DATA;
`else
          st_d = DATA;
`endif
        end
      end
`ifdef SPIFLASH_RESP_QUAD_EN
      MODE: if (rise) begin
        sh_d = {sh_q[19:0], io_s};
        cnt_d = cnt_q + CW'(1);
        if (cnt_q == CW'(1)) begin
          cnt_d = '0;
          crm_d = sh_d[5:4] == CRM_MODE_BITS;
          st_d = (DUMMY_CYCLES == 0) ? DATA : DUMMY;
        end
      end
      DUMMY: if (rise) begin
        cnt_d = cnt_q + CW'(1);
        if (cnt_q == CW'(DUMMY_CYCLES - 1)) begin
          cnt_d = '0;
          st_d = DATA;
        end
      end
`endif
      DATA: if (fall) begin
        cnt_d = (cnt_q == (quad_q ? CW'(1) : CW'(7))) ? '0 : cnt_q + CW'(1);
        do_d = quad_q ? dat[7:4] : {2'b00, dat[7], 1'b0};
        oe_d = quad_q ? 4'hF : 4'h2;
        sh_d[7:0] = quad_q ? {dat[3:0], 4'h0} : {dat[6:0], 1'b0};
        if (cnt_q == '0) begin
          err_d = err_q | ~(buf_v_q | hit);
          buf_v_d = 1'b0;
          rd_addr_d = rd_addr_q + 24'd1;
        end
      end
      default: oe_d = '0;
    endcase
    if (csb_s) begin
      st_d = IDLE;
      cnt_d = '0;
      oe_d = '0;
      mem_valid_d = 1'b0;
      buf_v_d = 1'b0;
    end
    if (st_d == DATA && !mem_valid_d && !buf_v_d) begin
      mem_valid_d = 1'b1;
      mem_addr_d = rd_addr_d;
    end
  end
  // state and output registers, cleared asynchronously
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      st_q <= IDLE;
      cnt_q <= '0;
      sh_q <= '0;
      rd_addr_q <= '0;
      buf_q <= '0;
      buf_v_q <= 1'b0;
      mem_valid_q <= 1'b0;
      mem_addr_q <= '0;
      do_q <= '0;
      oe_q <= '0;
      quad_q <= 1'b0;
      crm_q <= 1'b0;
      err_q <= 1'b0;
      busy_q <= 1'b0;
    end else begin
      st_q <= st_d;
      cnt_q <= cnt_d;
      sh_q <= sh_d;
      rd_addr_q <= rd_addr_d;
      buf_q <= buf_d;
      buf_v_q <= buf_v_d;
      mem_valid_q <= mem_valid_d;
      mem_addr_q <= mem_addr_d;
      do_q <= do_d;
      oe_q <= oe_d;
      quad_q <= quad_d;
      crm_q <= crm_d;
      err_q <= err_d;
      busy_q <= busy_d;
    end
  end
  assign {flash_io3_do, flash_io2_do, flash_io0_do} = {do_q[3], do_q[2], do_q[0]} & {3{QUAD_EN}};
  assign {flash_io3_oe, flash_io2_oe, flash_io0_oe} = {oe_q[3], oe_q[2], oe_q[0]} & {3{QUAD_EN}};
  assign flash_io1_do = do_q[1];
  assign flash_io1_oe = oe_q[1];
  assign mem_valid = mem_valid_q;
  assign mem_addr = mem_addr_q;
  assign busy = busy_q;
  assign err = err_q;
endmodule

// File: tb/tb_spiflash_responder.sv
// tb_spiflash_responder: host and byte-store models driving random reads against expected store contents
module tb_spiflash_responder;
  localparam int H = 4;
  localparam int DUMMY = 4;
  logic clk = 1'b0, resetn, flash_csb, flash_clk, mem_ready, mem_valid, busy, err;
  logic [3:0] host_io, dut_do, dut_oe, oe_seen;
  logic [23:0] mem_addr;
  logic [7:0] mem_rdata;
  logic [7:0] mem [logic [23:0]];
  logic [23:0] served [$];
  int lat, vecs, errs;
  always #5 clk = ~clk;
  spiflash_responder dut (
    .clk(clk), .resetn(resetn), .flash_csb(flash_csb), .flash_clk(flash_clk),
    .flash_io0_di(host_io[0]), .flash_io1_di(host_io[1]), .flash_io2_di(host_io[2]), .flash_io3_di(host_io[3]),
    .flash_io0_do(dut_do[0]), .flash_io1_do(dut_do[1]), .flash_io2_do(dut_do[2]), .flash_io3_do(dut_do[3]),
    .flash_io0_oe(dut_oe[0]), .flash_io1_oe(dut_oe[1]), .flash_io2_oe(dut_oe[2]), .flash_io3_oe(dut_oe[3]),
    .mem_valid(mem_valid), .mem_ready(mem_ready), .mem_addr(mem_addr), .mem_rdata(mem_rdata),
    .busy(busy), .err(err)
  );
  function automatic logic [7:0] mem_byte(input logic [23:0] a);
    return mem.exists(a) ? mem[a] : a[7:0] ^ a[15:8] ^ a[23:16] ^ 8'h5A;
  endfunction
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vecs++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  // byte store: answers a held request after lat cycles with a one-cycle ready pulse
  initial begin
    int c;
    c = 0;
    forever begin
      @(negedge clk);
      if (mem_ready) mem_ready = 1'b0;
      else if (mem_valid) begin
        if (c >= lat) begin
          mem_ready = 1'b1;
          mem_rdata = mem_byte(mem_addr);
          served.push_back(mem_addr);
          c = 0;
        end else c++;
      end else c = 0;
    end
  end
  task automatic cyc(input logic [3:0] drv, output logic [3:0] smp);
    host_io = drv;
    repeat (H) @(negedge clk);
    smp = dut_do;
    oe_seen |= dut_oe;
    flash_clk = 1'b1;
    repeat (H) @(negedge clk);
    oe_seen |= dut_oe;
    flash_clk = 1'b0;
  endtask
  task automatic send_byte(input logic [7:0] b);
    logic [3:0] s;
    for (int i = 7; i >= 0; i--) cyc({3'b000, b[i]}, s);
  endtask
  task automatic send_addr(input logic [23:0] a, input bit quad);
    logic [3:0] s;
    if (quad) for (int i = 5; i >= 0; i--) cyc(a[i*4 +: 4], s);
    else for (int i = 23; i >= 0; i--) cyc({3'b000, a[i]}, s);
  endtask
  task automatic recv(input bit quad, output logic [7:0] b);
    logic [3:0] s;
    b = '0;
    if (quad) begin
      cyc(4'h0, s);
      b[7:4] = s;
      cyc(4'h0, s);
      b[3:0] = s;
    end else for (int i = 0; i < 8; i++) begin
      cyc(4'h0, s);
      b = {b[6:0], s[1]};
    end
  endtask
  task automatic start();
    flash_csb = 1'b0;
    oe_seen = '0;
    repeat (H) @(negedge clk);
  endtask
  task automatic stop();
    flash_csb = 1'b1;
    host_io = '0;
    repeat (4 * H) @(negedge clk);
  endtask
  task automatic do_reset();
    resetn = 1'b0;
    repeat (2) @(negedge clk);
    resetn = 1'b1;
    repeat (2) @(negedge clk);
  endtask
  task automatic rd(input string tag, input logic [23:0] a, input int n, input bit quad, input bit skip, input logic [7:0] mode);
    logic [3:0] s;
    logic [7:0] b;
    logic [23:0] ai;
    start();
    chk({tag, "_busy"}, busy, 1);
    if (!skip) send_byte(quad ? 8'hEB : 8'h03);
    send_addr(a, quad);
    if (quad) begin
      cyc(mode[7:4], s);
      cyc(mode[3:0], s);
      repeat (DUMMY) cyc(4'h0, s);
    end
    for (int i = 0; i < n; i++) begin
      recv(quad, b);
      ai = a + 24'(i);
      chk($sformatf("%s_b%0d", tag, i), b, mem_byte(ai));
    end
    chk({tag, "_oe"}, oe_seen, quad ? 4'hF : 4'h2);
    stop();
  endtask
  initial begin
    #900us;
    $display("FAIL watchdog: got no completion, expected finish before time limit");
    $fatal(1);
  end
  initial begin
    logic [3:0] s;
    logic [7:0] b;
    int n;
    vecs = 0; errs = 0; lat = 0;
    flash_csb = 1'b1; flash_clk = 1'b0; host_io = '0; resetn = 1'b0; mem_ready = 1'b0; mem_rdata = '0;
    mem[24'h000100] = 8'hA5; mem[24'h000101] = 8'h3C; mem[24'h000102] = 8'h0F; mem[24'h000103] = 8'hF0;
    mem[24'hFFFFFF] = 8'h5E; mem[24'h000000] = 8'hC3;
    repeat (3) @(negedge clk);
    chk("rst_do", dut_do, 0);
    chk("rst_oe", dut_oe, 0);
    chk("rst_valid", mem_valid, 0);
    chk("rst_addr", mem_addr, 0);
    chk("rst_busy", busy, 0);
    chk("rst_err", err, 0);
    resetn = 1'b1;
    repeat (2) @(negedge clk);
    rd("single", 24'h000100, 4, 0, 0, 8'h00);
    chk("single_err", err, 0);
    served.delete();
    rd("wrap", 24'hFFFFFF, 2, 0, 0, 8'h00);
    chk("wrap_a0", served[0], 24'hFFFFFF);
    chk("wrap_a1", served[1], 24'h000000);
    repeat (6) rd("rnd", 24'($urandom), $urandom_range(1, 4), 0, 0, 8'h00);
    chk("rnd_err", err, 0);
`ifdef SPIFLASH_RESP_QUAD_EN
    rd("quad", 24'h001000, 4, 1, 0, 8'hA0);
    rd("crm", 24'h001000 + 24'($urandom_range(0, 255)), 2, 1, 1, 8'h00);
    rd("after_crm", 24'($urandom), 2, 0, 0, 8'h00);
    repeat (2) begin
      rd("qrnd", 24'($urandom), 3, 1, 0, 8'hA0);
      rd("qcrm", 24'($urandom), 2, 1, 1, 8'h20);
      rd("qrnd_single", 24'($urandom), 1, 0, 0, 8'h00);
    end
    chk("quad_err", err, 0);
`else
    start();
    send_byte(8'hEB);
    repeat (8) cyc(4'h0, s);
    chk("eb_oe", oe_seen, 0);
    stop();
    chk("eb_err", err, 1);
`endif
    do_reset();
    start();
    for (int i = 7; i >= 3; i--) cyc({3'b000, 8'h03 >> i} & 4'h1, s);
    flash_csb = 1'b1;
    n = 0;
    while (busy && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk("abort_busy_clks", n, 3);
    chk("abort_oe", oe_seen, 0);
    repeat (4 * H) @(negedge clk);
    rd("post_abort", 24'($urandom), 2, 0, 0, 8'h00);
    lat = 40;
    start();
    send_byte(8'h03);
    send_addr(24'($urandom), 0);
    recv(0, b);
    chk("late_byte", b, 8'hFF);
    chk("late_err", err, 1);
    repeat (3) cyc(4'h0, s);
    chk("late_err_hold", err, 1);
    chk("late_oe1", dut_oe, 4'h2);
    #2 resetn = 1'b0;
    #1;
    chk("arst_oe", dut_oe, 0);
    chk("arst_do", dut_do, 0);
    chk("arst_valid", mem_valid, 0);
    chk("arst_addr", mem_addr, 0);
    chk("arst_busy", busy, 0);
    chk("arst_err", err, 0);
    flash_csb = 1'b1;
    host_io = '0;
    repeat (4) @(negedge clk);
    resetn = 1'b1;
    lat = 0;
    repeat (4 * H) @(negedge clk);
    start();
    send_byte(8'h9F);
    repeat (16) cyc(4'h0, s);
    chk("unsup_oe", oe_seen, 0);
    stop();
    chk("unsup_err", err, 1);
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end
endmodule
